// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// with a fixed busy window, and serves MFHI/MFLO/MTHI/MTLO.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] smul_s, umul_s, res_s;
  logic [31:0] mag_a_s, mag_b_s, div_b_s;
  logic [31:0] uq_s, ur_s, sq_s, sr_s, udq_s, udr_s, udiv_b_s;

  // Signed divide works on magnitudes so that 0x80000000 / -1 wraps cleanly.
  always_comb begin
    smul_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    umul_s   = {32'd0, A} * {32'd0, B};
    mag_a_s  = A[31] ? (~A + 32'd1) : A;
    mag_b_s  = B[31] ? (~B + 32'd1) : B;
    div_b_s  = (mag_b_s == 32'd0) ? 32'd1 : mag_b_s;
    uq_s     = mag_a_s / div_b_s;
    ur_s     = mag_a_s % div_b_s;
    sq_s     = (A[31] ^ B[31]) ? (~uq_s + 32'd1) : uq_s;
    sr_s     = A[31] ? (~ur_s + 32'd1) : ur_s;
    udiv_b_s = (B == 32'd0) ? 32'd1 : B;
    udq_s    = A / udiv_b_s;
    udr_s    = A % udiv_b_s;
    case (op)
      OP_MULT:  res_s = smul_s;
      OP_MULTU: res_s = umul_s;
      OP_DIV:   res_s = (B == 32'd0) ? {hi_q, lo_q} : {sr_s, sq_s};
      OP_DIVU:  res_s = (B == 32'd0) ? {hi_q, lo_q} : {udr_s, udq_s};
      default:  res_s = 64'd0;
    endcase
  end

  // Next-state: accept or move HI/LO when idle, count down and commit when running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        case (op)
          OP_MULT, OP_MULTU: begin
            pend_d  = res_s;
            cnt_d   = MULT_CYCLES;
            state_d = RUN;
          end
          OP_DIV, OP_DIVU: begin
            pend_d  = res_s;
            cnt_d   = DIV_CYCLES;
            state_d = RUN;
          end
          OP_MTHI: hi_d = A;
          OP_MTLO: lo_d = A;
          default: state_d = IDLE;
        endcase
      end
      RUN: begin
        if (cnt_q == 32'd1) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          cnt_d   = 32'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    hi   = hi_q;
    lo   = lo_q;
    if (op == OP_MFHI) begin
      out = hi_q;
    end else if (op == OP_MFLO) begin
      out = lo_q;
    end else begin
      out = 32'd0;
    end
  end

endmodule
